// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: FSM state encoding and
// requester identifiers.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_L = 1'b1
    } req_id_t;

endpackage

// File: rtl/imem_arb_select.sv
// Tie-break between fetch and loader, with a starvation counter that lets
// fetch win a tie after STARVE_MAX consecutive tie losses.
module imem_arb_select
    import imem_arb_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter bit LOADER_PRIO = 1'b1
) (
    input  logic    clk,
    input  logic    sys_rst,
    input  logic    f_req,
    input  logic    l_req,
    input  logic    grant,
    output req_id_t winner
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          tie;

    assign tie = f_req & l_req;

    always_comb begin
        winner = REQ_F;
        if (l_req && !f_req) begin
            winner = REQ_L;
        end else if (tie && LOADER_PRIO && (starve_cnt != SW'(STARVE_MAX))) begin
            winner = REQ_L;
        end
    end

    // Only loader wins on a tie count as starvation; any fetch grant clears it.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == REQ_F) begin
                starve_cnt <= '0;
            end else if (tie) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction SRAM between the fetch port and the
// loader/debug port through an IDLE/ISSUE/WAIT/ACK sequence.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW          = 5,
    parameter int DW          = 32,
    parameter int WAIT_CYC    = 1,
    parameter int STARVE_MAX  = 4,
    parameter bit LOADER_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic [7:0]    conflict_cnt
);

    localparam int WCW = $clog2(WAIT_CYC + 1);

    state_t         state;
    req_id_t        winner;
    req_id_t        owner;
    logic [WCW-1:0] wait_cnt;
    logic           grant;

    assign grant = (state == IDLE) && (f_req || l_req);

    imem_arb_select #(
        .STARVE_MAX  (STARVE_MAX),
        .LOADER_PRIO (LOADER_PRIO)
    ) u_select (
        .clk     (clk),
        .sys_rst (sys_rst),
        .f_req   (f_req),
        .l_req   (l_req),
        .grant   (grant),
        .winner  (winner)
    );

    // m_addr/m_wdata double as the latched command; m_we keeps the latched
    // direction through ISSUE so the ISSUE step can pick write vs read.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= IDLE;
            owner        <= REQ_F;
            wait_cnt     <= '0;
            m_en         <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            f_ack        <= 1'b0;
            l_ack        <= 1'b0;
            f_rdata      <= '0;
            l_rdata      <= '0;
            busy         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_req && l_req && (conflict_cnt != 8'hFF)) begin
                        conflict_cnt <= conflict_cnt + 8'd1;
                    end
                    if (grant) begin
                        owner <= winner;
                        busy  <= 1'b1;
                        m_en  <= 1'b1;
                        state <= ISSUE;
                        if (winner == REQ_L) begin
                            m_we    <= l_we;
                            m_addr  <= l_addr;
                            m_wdata <= l_wdata;
                        end else begin
                            m_we   <= 1'b0;
                            m_addr <= f_addr;
                        end
                    end
                end
                ISSUE: begin
                    m_en <= 1'b0;
                    m_we <= 1'b0;
                    if (m_we) begin
                        state <= ACK;
                        f_ack <= (owner == REQ_F);
                        l_ack <= (owner == REQ_L);
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WCW'(WAIT_CYC);
                    end
                end
                WAIT: begin
                    if (wait_cnt == WCW'(1)) begin
                        if (owner == REQ_F) begin
                            f_rdata <= m_rdata;
                        end else begin
                            l_rdata <= m_rdata;
                        end
                        state <= ACK;
                        f_ack <= (owner == REQ_F);
                        l_ack <= (owner == REQ_L);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    f_ack <= 1'b0;
                    l_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: transaction-schedule reference model,
// directed literal checks and randomized traffic.
module tb_imem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WC = 1;
    localparam int SM = 4;
    localparam bit LP = 1'b1;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          f_req, l_req, l_we;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          f_ack, l_ack, m_en, m_we, busy;
    logic [DW-1:0] f_rdata, l_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
    logic [7:0]    conflict_cnt;

    logic          f_req3;
    logic [AW-1:0] f_addr3, m_addr3;
    logic          f_ack3, l_ack3, m_en3, m_we3, busy3;
    logic [DW-1:0] f_rdata3, l_rdata3, m_wdata3, m_rdata3;
    logic [7:0]    conflict3;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] mem3 [32];
    logic [DW-1:0] pipe3 [3];
    logic [DW-1:0] ref_mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WC), .STARVE_MAX(SM), .LOADER_PRIO(LP)) u_dut (
        .clk(clk), .sys_rst(sys_rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    imem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(3), .STARVE_MAX(SM), .LOADER_PRIO(LP)) u_dut3 (
        .clk(clk), .sys_rst(sys_rst),
        .f_req(f_req3), .f_addr(f_addr3), .f_ack(f_ack3), .f_rdata(f_rdata3),
        .l_req(1'b0), .l_we(1'b0), .l_addr(5'd0), .l_wdata(32'd0),
        .l_ack(l_ack3), .l_rdata(l_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
        .busy(busy3), .conflict_cnt(conflict3)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
    endfunction

    // SRAM models: read data is valid only in the cycle exactly WAIT_CYC after the command
    always @(posedge clk) begin
        m_rdata <= 32'hBAD0BAD0;
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    always @(posedge clk) begin
        pipe3[0] <= (m_en3 && !m_we3) ? mem3[m_addr3] : 32'hBAD0BAD0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (m_en3 && m_we3) mem3[m_addr3] <= m_wdata3;
    end
    assign m_rdata3 = pipe3[2];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: each grant schedules its issue and ack cycles; outputs follow the schedule
    int            cyc, free_at, t_iss, t_ack, sc, e_conf;
    bit            t_valid, t_we, t_win, win;
    logic [AW-1:0] t_addr, e_addr;
    logic [DW-1:0] t_wdata, t_rd, e_wdata, e_frd, e_lrd;
    bit            e_busy, e_en, e_we, e_fack, e_lack;

    always @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cyc = 0; free_at = 0; sc = 0; e_conf = 0; t_valid = 0;
            e_busy = 0; e_en = 0; e_we = 0; e_fack = 0; e_lack = 0;
            e_addr = '0; e_wdata = '0; e_frd = '0; e_lrd = '0;
        end else begin
            if (t_valid && cyc == t_iss) begin
                if (t_we) ref_mem[t_addr] = t_wdata;
                else      t_rd = ref_mem[t_addr];
            end
            if (t_valid && !t_we && cyc + 1 == t_ack) begin
                if (t_win) e_lrd = t_rd;
                else       e_frd = t_rd;
            end
            if (cyc >= free_at && (f_req || l_req)) begin
                if (f_req && l_req) e_conf = (e_conf < 255) ? e_conf + 1 : 255;
                if (!l_req)         win = 0;
                else if (!f_req)    win = 1;
                else if (!LP)       win = 0;
                else                win = (sc != SM);
                if (!win)       sc = 0;
                else if (f_req) sc = sc + 1;
                t_valid = 1;
                t_win   = win;
                t_we    = win ? l_we : 1'b0;
                t_addr  = win ? l_addr : f_addr;
                if (win) begin
                    t_wdata = l_wdata;
                    e_wdata = l_wdata;
                end
                e_addr  = t_addr;
                t_iss   = cyc + 1;
                t_ack   = t_we ? cyc + 2 : cyc + 2 + WC;
                free_at = t_ack + 1;
            end
            cyc    = cyc + 1;
            e_busy = t_valid && cyc >= t_iss && cyc <= t_ack;
            e_en   = t_valid && cyc == t_iss;
            e_we   = e_en && t_we;
            e_fack = t_valid && cyc == t_ack && !t_win;
            e_lack = t_valid && cyc == t_ack && t_win;
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        if (!sys_rst) begin
            check_output("rst_ctrl", 32'({m_en, m_we, f_ack, l_ack, busy}), 32'd0);
            check_output("rst_m_addr", 32'(m_addr), 32'd0);
            check_output("rst_m_wdata", m_wdata, 32'd0);
            check_output("rst_f_rdata", f_rdata, 32'd0);
            check_output("rst_l_rdata", l_rdata, 32'd0);
            check_output("rst_conflict", 32'(conflict_cnt), 32'd0);
        end else begin
            check_output("busy", 32'(busy), 32'(e_busy));
            check_output("m_en", 32'(m_en), 32'(e_en));
            check_output("m_we", 32'(m_we), 32'(e_we));
            check_output("f_ack", 32'(f_ack), 32'(e_fack));
            check_output("l_ack", 32'(l_ack), 32'(e_lack));
            check_output("m_addr", 32'(m_addr), 32'(e_addr));
            check_output("f_rdata", f_rdata, e_frd);
            check_output("l_rdata", l_rdata, e_lrd);
            check_output("conflict_cnt", 32'(conflict_cnt), 32'(e_conf));
            if (e_we) check_output("m_wdata", m_wdata, e_wdata);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        sys_rst = 1'b0;
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        sys_rst = 1'b1;
    endtask

    task automatic fetch_direct(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        f_req = 1'b1; f_addr = a;
        @(negedge clk);
        check_output("dir_f_m_en", 32'(m_en), 32'd1);
        check_output("dir_f_m_we", 32'(m_we), 32'd0);
        check_output("dir_f_m_addr", 32'(m_addr), 32'(a));
        @(negedge clk);
        check_output("dir_f_ack_early", 32'(f_ack), 32'd0);
        @(negedge clk);
        check_output("dir_f_ack", 32'(f_ack), 32'd1);
        check_output("dir_f_rdata", f_rdata, d);
        f_req = 1'b0;
        @(negedge clk);
        check_output("dir_f_ack_pulse", 32'(f_ack), 32'd0);
    endtask

    task automatic hold_both(input int n_acks, output string order);
        int got = 0;
        order = "";
        @(negedge clk);
        f_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
        f_addr = 5'd9; l_addr = 5'd12;
        for (int k = 0; k < n_acks * 8 && got < n_acks; k++) begin
            @(negedge clk);
            if (f_ack) begin order = {order, "F"}; got++; end
            if (l_ack) begin order = {order, "L"}; got++; end
        end
        f_req = 1'b0; l_req = 1'b0;
        if (got < n_acks) check_output("hold_both_timeout", 32'(got), 32'(n_acks));
    endtask

    task automatic apply_stimulus();
        @(negedge clk);
        #2;
        if (sys_rst && $urandom_range(0, 599) == 0) begin
            sys_rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
        end else if (!sys_rst) begin
            sys_rst = 1'b1;
        end else begin
            if (f_req ? f_ack : ($urandom_range(0, 2) == 0)) begin
                f_req  = f_req ? ($urandom_range(0, 3) == 0) : 1'b1;
                f_addr = 5'($urandom_range(0, 31));
            end
            if (l_req ? l_ack : ($urandom_range(0, 3) == 0)) begin
                l_req   = l_req ? ($urandom_range(0, 2) == 0) : 1'b1;
                l_we    = ($urandom_range(0, 1) == 1);
                l_addr  = 5'($urandom_range(0, 31));
                l_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string order;
        bit    seen;
        f_req = 0; l_req = 0; l_we = 0; f_addr = '0; l_addr = '0; l_wdata = '0;
        f_req3 = 0; f_addr3 = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     <= init_word(i);
            mem3[i]    <= init_word(i);
            ref_mem[i] = init_word(i);
        end

        // reset held with random inputs, then quiet idle
        repeat (4) begin
            @(negedge clk);
            f_req = ($urandom_range(0, 1) == 1); l_req = ($urandom_range(0, 1) == 1);
            l_we = ($urandom_range(0, 1) == 1); f_addr = 5'($urandom_range(0, 31));
            l_addr = 5'($urandom_range(0, 31)); l_wdata = $urandom;
        end
        @(negedge clk);
        f_req = 0; l_req = 0; l_we = 0;
        #2 sys_rst = 1'b1;
        repeat (5) @(negedge clk);

        fetch_direct(5'd5, 32'hDEADBEEF);

        // loader write, then read back through fetch
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b1; l_addr = 5'd3; l_wdata = 32'h12345678;
        @(negedge clk);
        check_output("dir_w_m_en", 32'(m_en), 32'd1);
        check_output("dir_w_m_we", 32'(m_we), 32'd1);
        check_output("dir_w_m_wdata", m_wdata, 32'h12345678);
        @(negedge clk);
        check_output("dir_w_l_ack", 32'(l_ack), 32'd1);
        check_output("dir_w_l_rdata", l_rdata, 32'd0);
        l_req = 1'b0; l_we = 1'b0;
        fetch_direct(5'd3, 32'h12345678);

        // continuous contention
        do_reset();
        hold_both(10, order);
        n_cmp++;
        if (order != "LLLLFLLLLF") begin
            n_bad++;
            $display("[TB] FAIL grant_order: got %s, expected LLLLFLLLLF", order);
        end
        @(negedge clk);
        check_output("conflict_10", 32'(conflict_cnt), 32'd10);

        // reset during WAIT of a fetch
        do_reset();
        @(negedge clk);
        f_req = 1'b1; f_addr = 5'd7;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = m_en;
        end
        check_output("abort_issue_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #2 sys_rst = 1'b0;
        #1;
        check_output("abort_m_en", 32'(m_en), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("abort_no_ack", 32'(f_ack), 32'd0);
        @(negedge clk);
        #2 sys_rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = f_ack;
        end
        check_output("abort_refetch_ack", 32'(seen), 32'd1);
        check_output("abort_refetch_data", f_rdata, init_word(7));
        f_req = 1'b0;

        // WAIT_CYC=3 instance: fetch ack five cycles after the request cycle
        @(negedge clk);
        f_req3 = 1'b1; f_addr3 = 5'd5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check_output("w3_m_en", 32'(m_en3), 32'd1);
            if (k == 5) begin
                check_output("w3_f_ack", 32'(f_ack3), 32'd1);
                check_output("w3_f_rdata", f_rdata3, 32'hDEADBEEF);
                f_req3 = 1'b0;
            end else begin
                check_output("w3_f_ack_idle", 32'(f_ack3), 32'd0);
            end
        end
        check_output("w3_loader_quiet", 32'({l_ack3, busy3, conflict3}), 32'd0);
        check_output("w3_l_rdata", l_rdata3, 32'd0);

        // conflict counter saturation
        do_reset();
        hold_both(300, order);
        @(negedge clk);
        check_output("conflict_sat", 32'(conflict_cnt), 32'd255);

        // randomized traffic with occasional resets
        repeat (3000) apply_stimulus();
        @(negedge clk);
        f_req = 1'b0; l_req = 1'b0;
        #2 sys_rst = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
